// File: rtl/sign_classifier_debounce.sv
// rtl/sign_classifier_debounce.sv - debounced positive/negative/zero classifier with change pulse and transition counter
module sign_classifier_debounce #(
  parameter int WIDTH = 16,
  parameter int HOLD  = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  input  logic             clear,
  output logic             positive_flag,
  output logic             negative_flag,
  output logic             zero_flag,
  output logic             change_pulse,
  output logic [CNT_W-1:0] trans_count
);

  // Run counter must hold values 0..HOLD inclusive.
  localparam int RUN_W = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
  localparam logic [RUN_W-1:0] HOLD_V = RUN_W'(HOLD);

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_POS  = 2'd1,
    CLS_NEG  = 2'd2
  } cls_e;

  cls_e             state_q, state_d;
  cls_e             cand_q, cand_d;
  cls_e             raw_cls;
  logic [RUN_W-1:0] run_q, run_d, run_next;
  logic             commit;
  logic             pos_q, pos_d;
  logic             neg_q, neg_d;
  logic             zero_q, zero_d;
  logic             change_q, change_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Raw class of the current sample; the sign bit decides once zero is excluded.
  always_comb begin
    raw_cls = CLS_POS;
    if (in == '0) begin
      raw_cls = CLS_ZERO;
    end else if (in[WIDTH-1]) begin
      raw_cls = CLS_NEG;
    end
  end

  // Next-state: track a candidate run and commit once HOLD agreeing valid samples are seen.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    run_d    = run_q;
    run_next = run_q;
    commit   = 1'b0;
    if (in_valid) begin
      if (raw_cls == state_q) begin
        run_next = '0;
      end else if (raw_cls == cand_q) begin
        run_next = run_q + 1'b1;
      end else begin
        cand_d   = raw_cls;
        run_next = {{(RUN_W-1){1'b0}}, 1'b1};
      end
      run_d = run_next;
      if ((raw_cls != state_q) && (run_next == HOLD_V)) begin
        commit  = 1'b1;
        state_d = raw_cls;
        run_d   = '0;
      end
    end
    pos_d    = (state_d == CLS_POS);
    neg_d    = (state_d == CLS_NEG);
    zero_d   = (state_d == CLS_ZERO);
    change_d = commit;
    // clear takes priority over a simultaneous commit; otherwise saturate at all-ones.
    cnt_d    = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (commit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Committed class, run tracking and registered outputs; reset forces ZERO asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CLS_ZERO;
      cand_q   <= CLS_ZERO;
      run_q    <= '0;
      pos_q    <= 1'b0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b1;
      change_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      run_q    <= run_d;
      pos_q    <= pos_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      change_q <= change_d;
      cnt_q    <= cnt_d;
    end
  end

  assign positive_flag = pos_q;
  assign negative_flag = neg_q;
  assign zero_flag     = zero_q;
  assign change_pulse  = change_q;
  assign trans_count   = cnt_q;

endmodule

// File: tb/tb_sign_classifier_debounce.sv
// tb/tb_sign_classifier_debounce.sv - directed self-checking bench for sign_classifier_debounce
module tb_sign_classifier_debounce;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_a, clear_a;
  logic [15:0] in_a;
  logic        pos_a, neg_a, zero_a, chg_a;
  logic [7:0]  cnt_a;
  logic        in_valid_b, clear_b;
  logic [15:0] in_b;
  logic        pos_b, neg_b, zero_b, chg_b;
  logic [1:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sign_classifier_debounce #(.WIDTH(16), .HOLD(3), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in(in_a), .clear(clear_a),
    .positive_flag(pos_a), .negative_flag(neg_a), .zero_flag(zero_a),
    .change_pulse(chg_a), .trans_count(cnt_a)
  );

  sign_classifier_debounce #(.WIDTH(16), .HOLD(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in(in_b), .clear(clear_b),
    .positive_flag(pos_b), .negative_flag(neg_b), .zero_flag(zero_b),
    .change_pulse(chg_b), .trans_count(cnt_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid_a = 0; in_a = 0; clear_a = 0;
    in_valid_b = 0; in_b = 0; clear_b = 0;
    tick(); tick();
    checks++;
    if ({pos_a, neg_a, zero_a, chg_a, cnt_a} !== {4'b0010, 8'd0}) begin
      errors++;
      $display("FAIL reset_held: got p%b n%b z%b c%b cnt%0d, expected p0 n0 z1 c0 cnt0", pos_a, neg_a, zero_a, chg_a, cnt_a);
    end
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if ({pos_a, neg_a, zero_a, chg_a, cnt_a} !== {4'b0010, 8'd0}) begin
      errors++;
      $display("FAIL reset_released: got p%b n%b z%b c%b cnt%0d, expected p0 n0 z1 c0 cnt0", pos_a, neg_a, zero_a, chg_a, cnt_a);
    end
    checks++;
    if ({pos_b, neg_b, zero_b, chg_b, cnt_b} !== {4'b0010, 2'd0}) begin
      errors++;
      $display("FAIL reset_b: got p%b n%b z%b c%b cnt%0d, expected p0 n0 z1 c0 cnt0", pos_b, neg_b, zero_b, chg_b, cnt_b);
    end
  endtask

  task automatic test_commit_pos();
    in_a = 16'd10; in_valid_a = 1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      checks++;
      if ({pos_a, neg_a, zero_a, chg_a} !== 4'b0010) begin
        errors++;
        $display("FAIL pos_early_%0d: got p%b n%b z%b c%b, expected p0 n0 z1 c0", i, pos_a, neg_a, zero_a, chg_a);
      end
    end
    tick();
    checks++;
    if ({pos_a, neg_a, zero_a, chg_a, cnt_a} !== {4'b1001, 8'd1}) begin
      errors++;
      $display("FAIL pos_commit: got p%b n%b z%b c%b cnt%0d, expected p1 n0 z0 c1 cnt1", pos_a, neg_a, zero_a, chg_a, cnt_a);
    end
    tick();
    checks++;
    if ({pos_a, chg_a, cnt_a} !== {2'b10, 8'd1}) begin
      errors++;
      $display("FAIL pos_pulse_end: got p%b c%b cnt%0d, expected p1 c0 cnt1", pos_a, chg_a, cnt_a);
    end
  endtask

  task automatic test_glitch();
    logic [15:0] seq [5];
    seq[0] = -16'sd5; seq[1] = -16'sd5; seq[2] = 16'd10; seq[3] = -16'sd5; seq[4] = -16'sd5;
    in_valid_a = 1;
    for (int i = 0; i < 5; i++) begin
      in_a = seq[i];
      tick();
      checks++;
      if ({pos_a, neg_a, zero_a, chg_a} !== 4'b1000) begin
        errors++;
        $display("FAIL glitch_hold_%0d: got p%b n%b z%b c%b, expected p1 n0 z0 c0", i, pos_a, neg_a, zero_a, chg_a);
      end
    end
    in_a = -16'sd5;
    tick();
    checks++;
    if ({pos_a, neg_a, zero_a, chg_a, cnt_a} !== {4'b0101, 8'd2}) begin
      errors++;
      $display("FAIL glitch_commit_neg: got p%b n%b z%b c%b cnt%0d, expected p0 n1 z0 c1 cnt2", pos_a, neg_a, zero_a, chg_a, cnt_a);
    end
  endtask

  task automatic test_valid_gaps();
    logic v [5];
    in_valid_a = 1; in_a = 16'd10;
    tick(); tick(); tick();
    checks++;
    if ({pos_a, cnt_a} !== {1'b1, 8'd3}) begin
      errors++;
      $display("FAIL gaps_setup_pos: got p%b cnt%0d, expected p1 cnt3", pos_a, cnt_a);
    end
    v[0] = 1; v[1] = 0; v[2] = 1; v[3] = 0; v[4] = 1;
    in_a = -16'sd12345;
    for (int i = 0; i < 5; i++) begin
      in_valid_a = v[i];
      tick();
      if (i < 4) begin
        checks++;
        if ({pos_a, neg_a, zero_a} !== 3'b100) begin
          errors++;
          $display("FAIL gaps_hold_%0d: got p%b n%b z%b, expected p1 n0 z0", i, pos_a, neg_a, zero_a);
        end
      end
    end
    checks++;
    if ({pos_a, neg_a, zero_a, chg_a, cnt_a} !== {4'b0101, 8'd4}) begin
      errors++;
      $display("FAIL gaps_commit_neg: got p%b n%b z%b c%b cnt%0d, expected p0 n1 z0 c1 cnt4", pos_a, neg_a, zero_a, chg_a, cnt_a);
    end
    in_valid_a = 0;
    for (int i = 0; i < 5; i++) begin
      in_a = (i % 2 == 0) ? 16'd0 : 16'd77;
      tick();
      checks++;
      if ({pos_a, neg_a, zero_a, chg_a, cnt_a} !== {4'b0100, 8'd4}) begin
        errors++;
        $display("FAIL invalid_ignored_%0d: got p%b n%b z%b c%b cnt%0d, expected p0 n1 z0 c0 cnt4", i, pos_a, neg_a, zero_a, chg_a, cnt_a);
      end
    end
  endtask

  task automatic test_extremes();
    logic [15:0] vals [3];
    logic [2:0]  exp_f [3];
    logic [2:0]  prev;
    vals[0] = 16'h7FFF; exp_f[0] = 3'b100;
    vals[1] = 16'h8000; exp_f[1] = 3'b010;
    vals[2] = 16'h0000; exp_f[2] = 3'b001;
    prev = 3'b010;
    in_valid_a = 1;
    for (int k = 0; k < 3; k++) begin
      in_a = vals[k];
      for (int c = 1; c <= 3; c++) begin
        tick();
        checks++;
        if ({pos_a, neg_a, zero_a} !== ((c == 3) ? exp_f[k] : prev)) begin
          errors++;
          $display("FAIL extreme_%0d_cyc%0d: got pnz=%b, expected %b", k, c, {pos_a, neg_a, zero_a}, (c == 3) ? exp_f[k] : prev);
        end
      end
      prev = exp_f[k];
    end
    checks++;
    if (cnt_a !== 8'd7) begin
      errors++;
      $display("FAIL extreme_count: got %0d, expected 7", cnt_a);
    end
    in_valid_a = 0;
  endtask

  task automatic test_saturate_clear();
    logic [15:0] seq [5];
    logic [2:0]  exp_f [5];
    logic [1:0]  exp_c [5];
    seq[0] = 16'd5;    exp_f[0] = 3'b100; exp_c[0] = 2'd1;
    seq[1] = -16'sd5;  exp_f[1] = 3'b010; exp_c[1] = 2'd2;
    seq[2] = 16'd5;    exp_f[2] = 3'b100; exp_c[2] = 2'd3;
    seq[3] = -16'sd5;  exp_f[3] = 3'b010; exp_c[3] = 2'd3;
    seq[4] = 16'd5;    exp_f[4] = 3'b100; exp_c[4] = 2'd3;
    in_valid_b = 1;
    for (int i = 0; i < 5; i++) begin
      in_b = seq[i];
      tick();
      checks++;
      if ({pos_b, neg_b, zero_b, chg_b, cnt_b} !== {exp_f[i], 1'b1, exp_c[i]}) begin
        errors++;
        $display("FAIL sat_%0d: got pnz=%b c%b cnt%0d, expected pnz=%b c1 cnt%0d", i, {pos_b, neg_b, zero_b}, chg_b, cnt_b, exp_f[i], exp_c[i]);
      end
    end
    in_b = -16'sd5; clear_b = 1;
    tick();
    checks++;
    if ({pos_b, neg_b, zero_b, chg_b, cnt_b} !== {4'b0101, 2'd0}) begin
      errors++;
      $display("FAIL clear_vs_commit: got pnz=%b c%b cnt%0d, expected pnz=010 c1 cnt0", {pos_b, neg_b, zero_b}, chg_b, cnt_b);
    end
    clear_b = 0;
    tick();
    checks++;
    if ({pos_b, neg_b, zero_b, chg_b, cnt_b} !== {4'b0100, 2'd0}) begin
      errors++;
      $display("FAIL after_clear: got pnz=%b c%b cnt%0d, expected pnz=010 c0 cnt0", {pos_b, neg_b, zero_b}, chg_b, cnt_b);
    end
    in_valid_b = 0;
  endtask

  task automatic test_async_reset();
    in_valid_a = 1; in_a = 16'd20;
    tick(); tick(); tick();
    checks++;
    if (pos_a !== 1'b1) begin
      errors++;
      $display("FAIL async_setup_pos: got p%b, expected p1", pos_a);
    end
    in_a = -16'sd3;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pos_a, neg_a, zero_a, chg_a, cnt_a} !== {4'b0010, 8'd0}) begin
      errors++;
      $display("FAIL async_reset: got p%b n%b z%b c%b cnt%0d, expected p0 n0 z1 c0 cnt0", pos_a, neg_a, zero_a, chg_a, cnt_a);
    end
    in_valid_a = 0;
    tick();
    rst_n = 1'b1;
    in_valid_a = 1; in_a = -16'sd3;
    tick(); tick();
    checks++;
    if ({neg_a, zero_a} !== 2'b01) begin
      errors++;
      $display("FAIL async_run_discarded: got n%b z%b, expected n0 z1", neg_a, zero_a);
    end
    tick();
    checks++;
    if ({neg_a, zero_a, cnt_a} !== {2'b10, 8'd1}) begin
      errors++;
      $display("FAIL async_resume: got n%b z%b cnt%0d, expected n1 z0 cnt1", neg_a, zero_a, cnt_a);
    end
    in_valid_a = 0;
  endtask

  initial begin
    test_reset();
    test_commit_pos();
    test_glitch();
    test_valid_gaps();
    test_extremes();
    test_saturate_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sign_classifier_debounce.md
Name: sign_classifier_debounce

Overview:
Parametrised successor to the single-width sign-flag block. It classifies a WIDTH-bit two's-complement sample stream as positive, negative or zero, and holds exactly one of three mutually exclusive flags. A new class is committed only after HOLD consecutive valid samples agree, which filters single-sample glitches. It also produces a one-cycle change pulse and a saturating transition counter for downstream monitoring logic.

Parameters:
WIDTH, 16, sample width in bits, two's complement, minimum 2.
HOLD, 3, consecutive agreeing valid samples required to commit a new class, minimum 1.
CNT_W, 8, width of the saturating transition counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  sample qualifier; `in` is ignored when low
in  input  WIDTH  signed sample
clear  input  1  synchronous clear of trans_count only
positive_flag  output  1  committed class is positive
negative_flag  output  1  committed class is negative
zero_flag  output  1  committed class is zero
change_pulse  output  1  high for exactly one cycle, in the first cycle the flags show a new class
trans_count  output  CNT_W  saturating count of committed class changes

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset state:
  - zero_flag=1; positive_flag=0; negative_flag=0.
  - change_pulse=0; trans_count=0.
  - candidate class = ZERO; run counter = 0.
- Raw class of `in`, combinational:
  - ZERO if in==0.
  - NEG if in[WIDTH-1]==1.
  - POS otherwise.
- State machine: committed states ZERO, POS, NEG. Outputs are one-hot from registered state only. Exactly one flag is high in every cycle, including during reset.
- Run counter: width clog2(HOLD+1). Updated only on in_valid=1 cycles:
  - raw == committed: run counter <= 0.
  - raw != committed and raw == candidate: run counter += 1.
  - raw != committed and raw != candidate: candidate <= raw; run counter <= 1.
- Commit rule:
  - Commit when the updated run count equals HOLD. Committed <= raw; run counter <= 0 at the same edge.
  - Flags change at that edge, so they are visible in the cycle after the HOLD-th agreeing sample is presented.
  - HOLD=1 gives a one-cycle registered classifier.
- in_valid=0 cycles: committed state, candidate and run counter all hold. Gaps do not break a run.
- change_pulse: registered. High in the single cycle following a commit edge, low otherwise. Back-to-back commits cannot occur when HOLD>=2. With HOLD=1, change_pulse may stay high across consecutive cycles, one pulse per commit.
- trans_count:
  - Increments by 1 on each commit edge.
  - Saturates at 2^CNT_W-1 and never wraps.
  - clear=1 sets it to 0 at the next edge. clear wins over a simultaneous commit (result 0).
  - clear does not affect flags or the run state.
- Boundaries:
  - in = most negative value (0x8000 for WIDTH=16) classifies as NEG.
  - in = 0x7FFF classifies as POS.
- Reset mid-run: flags return to ZERO and the run is discarded immediately and asynchronously, not at a clock edge. Normal operation resumes from the first rising clk edge after rst_n deasserts.

Test Plan:
1. Reset behaviour -> while rst_n=0 and after release with in_valid=0: zero_flag=1, other flags 0, change_pulse=0, trans_count=0. Assert rst_n=0 mid-run -> flags go to ZERO without waiting for a clk edge.
2. Commit to POS (HOLD=3) -> in=10, in_valid=1 for 3 cycles: positive_flag=1 in the cycle after the 3rd sample, change_pulse high that cycle only, trans_count=1.
3. Glitch rejection (from POS) -> in=-5 for 2 samples, then 10, then -5 for 2 samples: flags unchanged. One further -5 -> negative_flag=1, trans_count=2.
4. Valid gaps (from POS) -> in=-12345 with in_valid pattern 1,0,1,0,1: negative_flag=1 only after the 3rd valid sample. With in_valid=0 throughout, `in` changes have no effect.
5. Extremes, one commit each -> in=32767 gives POS, in=-32768 gives NEG, in=0 gives ZERO. Exactly one flag is high in every sampled cycle of the run.
6. Saturation and clear (CNT_W=2, HOLD=1) -> alternate 5/-5 for 5 valid cycles: trans_count reaches 3 and holds. Assert clear in the same cycle as a commit -> trans_count=0 and flags still update.
